// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - alu_pkg: ALU op codes, width defaults, entry type and op legality check
package alu_pkg;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_OP_W   = 4;

    localparam logic [DEF_REG_AW-1:0] XZR_IDX = 5'd31;

    localparam logic [DEF_OP_W-1:0] OP_AND    = 4'b0000;
    localparam logic [DEF_OP_W-1:0] OP_ORR    = 4'b0001;
    localparam logic [DEF_OP_W-1:0] OP_ADD    = 4'b0010;
    localparam logic [DEF_OP_W-1:0] OP_SUB    = 4'b0110;
    localparam logic [DEF_OP_W-1:0] OP_PASS_B = 4'b0111;
    localparam logic [DEF_OP_W-1:0] OP_NOR    = 4'b1100;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] input1;
        logic [DEF_DATA_W-1:0] input2;
        logic [DEF_OP_W-1:0]   op;
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_REG_AW-1:0] rs1;
        logic [DEF_REG_AW-1:0] rs2;
        logic                  use_imm;
        logic                  reg_write;
        logic                  illegal;
    } entry_t;

    function automatic logic is_legal_op(input logic [DEF_OP_W-1:0] op);
        case (op)
            OP_AND, OP_ORR, OP_ADD, OP_SUB, OP_PASS_B, OP_NOR: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side and ALU-side handshake bundle of the ID/EX stage
interface id_ex_stage_if
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int OP_W   = DEF_OP_W
) ();
    logic              id_valid;
    logic              id_ready;
    logic [OP_W-1:0]   id_alu_op;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [DATA_W-1:0] id_rs1_val;
    logic [DATA_W-1:0] id_rs2_val;
    logic [DATA_W-1:0] id_imm;
    logic              id_use_imm;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;

    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_input1;
    logic [DATA_W-1:0] ex_input2;
    logic [OP_W-1:0]   ex_operation;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_illegal;

    // slave is the pipeline stage; master is the decode/ALU environment around it
    modport slave (
        input  id_valid, id_alu_op, id_rs1, id_rs2, id_rs1_val, id_rs2_val,
               id_imm, id_use_imm, id_rd, id_reg_write, ex_ready,
        output id_ready, ex_valid, ex_input1, ex_input2, ex_operation,
               ex_rd, ex_reg_write, ex_illegal
    );

    modport master (
        output id_valid, id_alu_op, id_rs1, id_rs2, id_rs1_val, id_rs2_val,
               id_imm, id_use_imm, id_rd, id_reg_write, ex_ready,
        input  id_ready, ex_valid, ex_input1, ex_input2, ex_operation,
               ex_rd, ex_reg_write, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - id_ex_fwd_mux: EX/MEM > MEM/WB > regfile operand select, index 31 reads zero
module id_ex_fwd_mux
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [DATA_W-1:0] rs_val,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] val
);
    always_comb begin
        val = rs_val;
        if (rs == REG_AW'(XZR_IDX)) begin
            val = '0;
        end else if (exm_reg_write && (exm_rd == rs)) begin
            val = exm_result;
        end else if (wb_reg_write && (wb_rd == rs)) begin
            val = wb_result;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX stage: forwarding, immediate select, 2-entry skid buffer to the ALU
// Optional ID_EX_STALL_CNT_EN adds a saturating stall_cnt output.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    id_ex_stage_if.slave      bus,
    input  logic              flush,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    entry_t            main_q, skid_q, main_d, skid_d, main_s, skid_s, new_e;
    logic              main_v, skid_v, main_v_d, skid_v_d;
    logic              xfer, acc, wb_hit;
    logic [DATA_W-1:0] fwd1, fwd2;
    logic [OP_W-1:0]   op_in;

    id_ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs(bus.id_rs1), .rs_val(bus.id_rs1_val),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .val(fwd1)
    );

    id_ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs(bus.id_rs2), .rs_val(bus.id_rs2_val),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .val(fwd2)
    );

    // Held entries pick up late WB writes; immediates and x31 are never overwritten
    function automatic entry_t snoop(input entry_t e, input logic en,
                                     input logic [DEF_REG_AW-1:0] rd,
                                     input logic [DEF_DATA_W-1:0] res);
        entry_t r;
        r = e;
        if (en) begin
            if (rd == e.rs1) r.input1 = res;
            if (!e.use_imm && (rd == e.rs2)) r.input2 = res;
        end
        return r;
    endfunction

    assign wb_hit = wb_reg_write && (wb_rd != REG_AW'(XZR_IDX));
    assign main_s = snoop(main_q, main_v && wb_hit, wb_rd, wb_result);
    assign skid_s = snoop(skid_q, skid_v && wb_hit, wb_rd, wb_result);
    assign op_in  = bus.id_alu_op;

    always_comb begin
        new_e         = '0;
        new_e.rs1     = bus.id_rs1;
        new_e.rs2     = bus.id_rs2;
        new_e.rd      = bus.id_rd;
        new_e.use_imm = bus.id_use_imm;
        new_e.input1  = fwd1;
        new_e.input2  = bus.id_use_imm ? bus.id_imm : fwd2;
        if (is_legal_op(op_in)) begin
            new_e.op        = op_in;
            new_e.reg_write = bus.id_reg_write;
        end else begin
            new_e.illegal = 1'b1;
        end
    end

    assign xfer = main_v && bus.ex_ready;
    assign acc  = bus.id_valid && !skid_v;

    always_comb begin
        main_d   = main_s;
        skid_d   = skid_s;
        main_v_d = main_v;
        skid_v_d = skid_v;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v || xfer) begin
            if (skid_v) begin
                main_d   = skid_s;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (acc) begin
                main_d   = new_e;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (acc) begin
            skid_d   = new_e;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            main_v <= main_v_d;
            skid_v <= skid_v_d;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (main_v && !bus.ex_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    assign bus.id_ready     = !skid_v;
    assign bus.ex_valid     = main_v;
    assign bus.ex_input1    = main_q.input1;
    assign bus.ex_input2    = main_q.input2;
    assign bus.ex_operation = main_q.op;
    assign bus.ex_rd        = main_q.rd;
    assign bus.ex_reg_write = main_q.reg_write;
    assign bus.ex_illegal   = main_q.illegal;
endmodule
